uart_cmd_seq: RTL
=================

Name: uart_cmd_seq

Overview:
Synthesizable host-side UART command sequencer: replays a programmable byte table (e.g. CPU_RST 0x2a, CONF_WR 0x2c + 8 bytes, DATA_WR 0x2e + payload, DATA_RD 0x2f) into a uart_tx with valid/ready handshake.
- Captures reply bytes from uart_rx into a response FIFO.
- Supersedes the fixed-table stimulus loop: parametrised table/response depth, programmable inter-byte gap, one-shot or loop mode, abort.
- Sits between uart_tx/uart_rx and a controller (bench, JTAG bridge or soft core) for in-system loading of ram_rw.

Parameters:
- TBL_DEPTH, 64, command-table entries (power of 2); TA = $clog2(TBL_DEPTH).
- RSP_DEPTH, 16, response-FIFO entries (power of 2); RA = $clog2(RSP_DEPTH).
- GAP_W, 16, width of inter-byte gap counter.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- tbl_wr_en_i  in  1  table write strobe
- tbl_wr_addr_i  in  TA  table write address
- tbl_wr_data_i  in  8  table write data
- tbl_len_i  in  TA+1  bytes to send, 0..TBL_DEPTH; sampled at start
- loop_i  in  1  1 = wrap to entry 0 after last byte; sampled at start
- gap_i  in  GAP_W  idle cycles between accepted byte and next vld; sampled at start
- start_i  in  1  start pulse
- stop_i  in  1  abort request
- tx_data_o  out  8  byte to uart_tx
- tx_data_vld_o  out  1  byte valid
- tx_data_rdy_i  in  1  uart_tx ready
- rx_data_i  in  8  byte from uart_rx
- rx_data_vld_i  in  1  rx byte valid, one-cycle pulse
- rx_data_rdy_o  out  1  always 1
- rsp_rd_en_i  in  1  pop response FIFO
- rsp_data_o  out  8  FIFO head, first-word fall-through
- rsp_cnt_o  out  RA+1  FIFO occupancy
- busy_o  out  1  sequence active
- done_o  out  1  one-cycle pulse at sequence end
- rsp_ovf_o  out  1  sticky overflow flag

Behaviour:
- Reset: tx_data_o=0, tx_data_vld_o=0, busy_o=0, done_o=0, rsp_ovf_o=0, rsp_cnt_o=0, rsp_data_o=0, rx_data_rdy_o=1.
- Table RAM is not reset.
- Table: synchronous-write, synchronous-read, 1-cycle read latency. Writes while busy_o=1 are ignored.
- FSM states: IDLE, FETCH, SEND, GAP, FIN.
  - IDLE: start_i → latch len/loop/gap, idx=0, clear rsp_ovf_o. If len=0 → FIN, else → FETCH; busy_o=1 from the next cycle.
  - FETCH: issue table read of idx; next cycle load tx_data_o, assert vld → SEND.
  - SEND: hold tx_data_o/vld stable until tx_data_vld_o&tx_data_rdy_i. The byte transfers on that edge; vld deasserts the next cycle. Then idx+1:
    - if idx+1==len and !loop → FIN;
    - if idx+1==len and loop → idx=0;
    - gap==0 → FETCH, else → GAP.
  - GAP: count gap cycles → FETCH. Back-to-back throughput with gap=0 is one byte per 3 cycles.
  - FIN: done_o=1 for one cycle, busy_o=0 → IDLE.
- start_i while busy_o=1 is ignored.
- stop_i:
  - in FETCH/GAP → FIN next cycle;
  - in SEND → the current byte completes its handshake, then FIN (no vld retraction);
  - in IDLE → ignored.
- Response FIFO:
  - rx_data_vld_i pushes rx_data_i in every state.
  - rsp_rd_en_i pops when cnt>0; pop on empty is ignored.
  - Push and pop in the same cycle: cnt unchanged, allowed even when full.
  - Push while full without pop: byte dropped, rsp_ovf_o=1. It stays set until the next accepted start_i or reset.
  - rsp_data_o is valid whenever cnt>0.
- Pointers wrap modulo RSP_DEPTH; idx wraps modulo len.
- Async reset mid-sequence: all state to IDLE immediately, vld low; FIFO emptied.

Test Plan:
- Load 0x2a,0x2c,0x00,0x00,0x00,0x40,0x1f,0x00,0x00,0x00; len=10, gap=0, rdy=1 → exactly 10 handshakes in table order, single done_o pulse, busy_o low after.
- len=3 bytes 0x2e,0x55,0xaa; rdy low 20 cycles during byte 2 → 0x55 held stable with vld=1 throughout, no duplicate or skipped byte.
- gap=5, len=2 → exactly 5 cycles from first transfer to the cycle after FETCH; second vld appears at transfer+7.
- loop=1, len=2 (0x2b,0x2f) → sequence 2b,2f,2b,2f…; stop_i mid-SEND → current byte completes, done_o pulses, no further vld.
- RSP_DEPTH=16: push 17 bytes 0x00..0x10 without pop → cnt=16, rsp_ovf_o=1, pops return 0x00..0x0f. Push+pop when full → cnt stays 16.
- len=0 start → done_o one cycle later, no vld. start_i while busy → ignored. Reset mid-SEND → vld low, busy_o=0, cnt=0.

Source files
------------

// File: rtl/uart_cmd_seq.sv
// Host-side UART command sequencer: replays a byte table into uart_tx over a
// valid/ready handshake and collects uart_rx replies in a first-word-fall-through FIFO.
module uart_cmd_seq #(
    parameter  int TBL_DEPTH = 64,
    parameter  int RSP_DEPTH = 16,
    parameter  int GAP_W     = 16,
    localparam int TA        = $clog2(TBL_DEPTH),
    localparam int RA        = $clog2(RSP_DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             tbl_wr_en_i,
    input  logic [TA-1:0]    tbl_wr_addr_i,
    input  logic [7:0]       tbl_wr_data_i,
    input  logic [TA:0]      tbl_len_i,
    input  logic             loop_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             start_i,
    input  logic             stop_i,
    output logic [7:0]       tx_data_o,
    output logic             tx_data_vld_o,
    input  logic             tx_data_rdy_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_data_vld_i,
    output logic             rx_data_rdy_o,
    input  logic             rsp_rd_en_i,
    output logic [7:0]       rsp_data_o,
    output logic [RA:0]      rsp_cnt_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             rsp_ovf_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_GAP,
        S_FIN
    } state_t;

    state_t           state;
    logic [TA:0]      len_q;
    logic             loop_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [TA:0]      idx;
    logic [TA:0]      idx_nxt;
    logic             last_byte;
    logic             fetch_p1;
    logic             stop_pend;
    logic             start_acc;

    logic [7:0]       tbl_mem [TBL_DEPTH];
    logic [7:0]       rd_data_p1;

    assign idx_nxt   = idx + (TA+1)'(1);
    assign last_byte = (idx_nxt == len_q);
    assign start_acc = start_i && (state == S_IDLE);

    assign rx_data_rdy_o = 1'b1;

    // Stage p0 -> p1: table read, one cycle latency; loading is locked out while a sequence runs
    always_ff @(posedge clk_i) begin
        if (tbl_wr_en_i && !busy_o)
            tbl_mem[tbl_wr_addr_i] <= tbl_wr_data_i;
        rd_data_p1 <= tbl_mem[idx[TA-1:0]];
    end

    // Stage p1 -> output: sequencer FSM, all outputs registered
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= S_IDLE;
            tx_data_o     <= 8'h00;
            tx_data_vld_o <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            len_q         <= '0;
            loop_q        <= 1'b0;
            gap_q         <= '0;
            gap_cnt       <= '0;
            idx           <= '0;
            fetch_p1      <= 1'b0;
            stop_pend     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        len_q     <= tbl_len_i;
                        loop_q    <= loop_i;
                        gap_q     <= gap_i;
                        idx       <= '0;
                        fetch_p1  <= 1'b0;
                        stop_pend <= 1'b0;
                        if (tbl_len_i == '0) begin
                            state  <= S_FIN;
                            done_o <= 1'b1;
                        end else begin
                            state  <= S_FETCH;
                            busy_o <= 1'b1;
                        end
                    end
                end

                S_FETCH: begin
                    if (stop_i) begin
                        state    <= S_FIN;
                        done_o   <= 1'b1;
                        busy_o   <= 1'b0;
                        fetch_p1 <= 1'b0;
                    end else if (!fetch_p1) begin
                        fetch_p1 <= 1'b1;
                    end else begin
                        fetch_p1      <= 1'b0;
                        tx_data_o     <= rd_data_p1;
                        tx_data_vld_o <= 1'b1;
                        state         <= S_SEND;
                    end
                end

                S_SEND: begin
                    // An abort here is deferred: the byte already offered must complete
                    if (stop_i)
                        stop_pend <= 1'b1;
                    if (tx_data_rdy_i) begin
                        tx_data_vld_o <= 1'b0;
                        if ((last_byte && !loop_q) || stop_i || stop_pend) begin
                            state  <= S_FIN;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                        end else begin
                            idx <= last_byte ? '0 : idx_nxt;
                            if (gap_q == '0) begin
                                state <= S_FETCH;
                            end else begin
                                gap_cnt <= gap_q;
                                state   <= S_GAP;
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (stop_i) begin
                        state  <= S_FIN;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                    end else if (gap_cnt <= GAP_W'(1)) begin
                        state <= S_FETCH;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end

                S_FIN: begin
                    state <= S_IDLE;
                end

                default: begin
                    state         <= S_IDLE;
                    tx_data_vld_o <= 1'b0;
                    busy_o        <= 1'b0;
                end
            endcase
        end
    end

    logic [7:0]    rsp_mem [RSP_DEPTH];
    logic [RA-1:0] wr_ptr;
    logic [RA-1:0] rd_ptr;
    logic          rsp_full;
    logic          do_push;
    logic          do_pop;

    // A pop frees the slot in the same cycle, so push+pop is accepted even when full
    assign rsp_full = (rsp_cnt_o == (RA+1)'(RSP_DEPTH));
    assign do_pop   = rsp_rd_en_i && (rsp_cnt_o != '0);
    assign do_push  = rx_data_vld_i && (!rsp_full || do_pop);

    assign rsp_data_o = (rsp_cnt_o != '0) ? rsp_mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk_i) begin
        if (do_push)
            rsp_mem[wr_ptr] <= rx_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rsp_cnt_o <= '0;
            rsp_ovf_o <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + RA'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + RA'(1);
            if (do_push && !do_pop)
                rsp_cnt_o <= rsp_cnt_o + (RA+1)'(1);
            else if (do_pop && !do_push)
                rsp_cnt_o <= rsp_cnt_o - (RA+1)'(1);
            if (start_acc)
                rsp_ovf_o <= 1'b0;
            if (rx_data_vld_i && !do_push)
                rsp_ovf_o <= 1'b1;
        end
    end

endmodule
